aes_mem_block_dma: RTL and testbench
====================================

# aes_mem_block_dma

Avalon-MM master that moves 128-bit AES blocks between the 32-bit single-port on-chip memory and the AES core. For each block it reads four consecutive words, presents them as one block on a valid/ready stream to the core, accepts the 128-bit result, and writes it back as four words to a destination region. It connects directly to the memory's `s1` slave port, with no waitrequest and a fixed one-cycle read latency.

## Interface
Parameters:
- `DEPTH`, 25000: memory size in 32-bit words.
- `AW`, 15: word-address width.
- `NBW`, 13: width of the block-count field.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `src_addr`  in  AW  first source word address.
- `dst_addr`  in  AW  first destination word address.
- `num_blocks`  in  NBW  number of 128-bit blocks to move.
- `busy`  out  1  high from the cycle after an accepted start until DONE completes.
- `done`  out  1  one-cycle pulse at the end of a job.
- `err`  out  1  one-cycle pulse when a start is rejected.
- `address`  out  AW  memory word address.
- `chipselect`  out  1  memory select.
- `write`  out  1  memory write strobe.
- `byteenable`  out  4  byte enables; always 4'hF when `write` is high.
- `writedata`  out  32  memory write data.
- `readdata`  in  32  memory read data; valid one cycle after the address.
- `clken`  out  1  memory clock enable; constant 1.
- `blk_out_data`  out  128  plaintext block to the core.
- `blk_out_valid`  out  1  block offered to the core.
- `blk_out_ready`  in  1  core accepts the block.
- `blk_in_data`  in  128  result block from the core.
- `blk_in_valid`  in  1  result offered by the core.
- `blk_in_ready`  out  1  DMA accepts the result.

## Operation
- Word order: word k of a block (k = 0..3, at address base+k) maps to bits [127-32k -: 32]. The same mapping is used for reads and writes.
- Start check:
  - Compute `src_addr + 4*num_blocks` and `dst_addr + 4*num_blocks` in AW+3 bits.
  - If either exceeds DEPTH: pulse `err` for one cycle, do no bus activity, and stay in IDLE.
  - If `num_blocks == 0`: go straight to DONE.
- States:
  - IDLE: wait for `start`.
  - RD: issue 4 read addresses.
  - RD_LAST: capture word 3.
  - OFFER: `blk_out_valid` high.
  - WAIT_RES: `blk_in_ready` high.
  - WR: 4 write cycles.
  - DONE: `done` high, then return to IDLE.
- After WR: if blocks remain, go to RD with both pointers advanced by 4; otherwise go to DONE.
- `start` outside IDLE is ignored. Source and destination regions may overlap; each block is fully read before it is written.
- Reset values: all outputs 0 except `clken`=1. State is IDLE. Pointers, counters and block registers are cleared.
- Reset mid-job: all outputs return to reset values at the next edge. Writes already completed stay in memory. No `done` pulse is produced.

## Timing
- `start` is sampled at edge 0.
- Read phase:
  - Cycles 1–4: `chipselect`=1, `write`=0, `address` = src..src+3.
  - `readdata` for the address driven in cycle n is captured at the end of cycle n+1. Word 3 is captured in cycle 5 (RD_LAST).
- Offer phase:
  - Cycle 6: `blk_out_valid`=1.
  - `blk_out_valid` and `blk_out_data` hold stable until `blk_out_ready` is high. The transfer happens on the edge where both are high.
- Result phase:
  - In the next cycle `blk_in_ready`=1. It stays high until `blk_in_valid` is high.
  - `blk_in_data` is registered on that handshake edge.
- Write phase: in the next 4 cycles, `chipselect`=`write`=1, `address` = dst..dst+3, and `writedata` = the mapped words.
- Minimum time per block is 12 cycles (RD 4, RD_LAST 1, OFFER 1, WAIT_RES 1, WR 4, plus the transition cycle into the next RD or DONE).
- `done` goes high in the cycle after the last write. `busy` falls in the same cycle as `done`.
- `chipselect` is low in every state except RD and WR.

## Structure
- Package `aes_dma_pkg` holds:
  - the state enum;
  - `WORDS_PER_BLK` = 4;
  - the word-index-to-bit-slice function, shared by reads and writes.
- Sub-module `aes_word_packer`:
  - a 4x32 ↔ 128 register;
  - load-word-by-index and load-block inputs;
  - word-select output.

## Test plan
- Single block: src=0x0000, dst=0x0100, num=1, memory preloaded with 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, core stub returns the bitwise inverse.
  - `blk_out_data` = 0x00112233_44556677_8899AABB_CCDDEEFF.
  - Words 0x100–0x103 = 0xFFEEDDCC … 0x33221100.
  - `done` at cycle 12.
- Backpressure: `blk_out_ready` held low for 5 cycles, then `blk_in_valid` delayed 7 cycles.
  - `blk_out_data` and `blk_out_valid` stay stable throughout the stall.
  - No bus activity during the stalls.
  - Memory contents are correct afterwards.
- Range error: src=24996, num=2 → `err` pulse, `busy` stays 0, `chipselect` never asserted.
- Zero blocks: num=0 → `done` pulse, no bus cycles.
- Multi-block: 3 blocks with in-place overlap (src=dst=0x0200) → all 12 words transformed; `start` pulses during the job are ignored.
- Reset mid-WR: assert `reset` after the 2nd write → next cycle all outputs are at reset values, only words 0–1 of the destination are modified, and a fresh `start` runs the job normally.

Source files
------------

// File: rtl/aes_dma_pkg.sv
// Shared types for the AES block DMA: FSM states and the word-to-lane mapping
// used identically when gathering read words and scattering write words.
package aes_dma_pkg;

  localparam int WORDS_PER_BLK = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_LAST,
    ST_OFFER,
    ST_WAIT_RES,
    ST_WR,
    ST_NEXT,
    ST_DONE
  } state_t;

  // Word k of a block occupies bits [127-32k -: 32], i.e. word 0 is the MSW.
  function automatic logic [6:0] word_lsb(input logic [1:0] idx);
    return 7'd96 - {idx, 5'd0};
  endfunction

endpackage

// File: rtl/aes_word_packer.sv
// 4x32 <-> 128-bit block register; loads one word by index or a whole block,
// single-cycle load latency, word select is combinational. No backpressure.
module aes_word_packer
  import aes_dma_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_ld_word,
  input  logic [1:0]   i_wr_idx,
  input  logic [31:0]  i_word,
  input  logic         i_ld_blk,
  input  logic [127:0] i_blk,
  input  logic [1:0]   i_rd_idx,
  output logic [127:0] o_blk,
  output logic [31:0]  o_word
);

  logic [127:0] r_blk;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_blk <= '0;
    end else if (i_ld_blk) begin
      r_blk <= i_blk;
    end else if (i_ld_word) begin
      r_blk[word_lsb(i_wr_idx) +: 32] <= i_word;
    end
  end

  assign o_blk  = r_blk;
  assign o_word = r_blk[word_lsb(i_rd_idx) +: 32];

endmodule

// File: rtl/aes_mem_block_dma.sv
// Avalon-MM DMA moving 128-bit blocks memory -> AES core -> memory; >= 12 cycles
// per block. Stalls without bus activity while the core withholds ready/valid.
module aes_mem_block_dma
  import aes_dma_pkg::*;
#(
  parameter int DEPTH = 25000,
  parameter int AW    = 15,
  parameter int NBW   = 13
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_start,
  input  logic [AW-1:0]  i_src_addr,
  input  logic [AW-1:0]  i_dst_addr,
  input  logic [NBW-1:0] i_num_blocks,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err,
  output logic [AW-1:0]  o_address,
  output logic           o_chipselect,
  output logic           o_write,
  output logic [3:0]     o_byteenable,
  output logic [31:0]    o_writedata,
  input  logic [31:0]    i_readdata,
  output logic           o_clken,
  output logic [127:0]   o_blk_out_data,
  output logic           o_blk_out_valid,
  input  logic           i_blk_out_ready,
  input  logic [127:0]   i_blk_in_data,
  input  logic           i_blk_in_valid,
  output logic           o_blk_in_ready
);

  localparam int EW = AW + 3;

  state_t         r_state;
  state_t         w_next;
  logic [AW-1:0]  r_src;
  logic [AW-1:0]  r_dst;
  logic [NBW-1:0] r_left;
  logic [1:0]     r_idx;
  logic           r_err;

  logic [EW-1:0]  w_src_end;
  logic [EW-1:0]  w_dst_end;
  logic           w_range_bad;
  logic           w_accept;
  logic           w_ld_word;
  logic           w_ld_blk;
  logic [127:0]   w_blk;
  logic [31:0]    w_word;

  assign w_src_end   = EW'(i_src_addr) + (EW'(i_num_blocks) << 2);
  assign w_dst_end   = EW'(i_dst_addr) + (EW'(i_num_blocks) << 2);
  assign w_range_bad = (w_src_end > EW'(DEPTH)) || (w_dst_end > EW'(DEPTH));
  assign w_accept    = (r_state == ST_IDLE) && i_start && !w_range_bad;

  // Read data trails the address by one cycle, so RD cycle n captures word n-1
  // and RD_LAST (r_idx wrapped to 0) captures word 3.
  assign w_ld_word = ((r_state == ST_RD) && (r_idx != 2'd0)) || (r_state == ST_RD_LAST);
  assign w_ld_blk  = (r_state == ST_WAIT_RES) && i_blk_in_valid;

  aes_word_packer u_packer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_ld_word (w_ld_word),
    .i_wr_idx  (r_idx - 2'd1),
    .i_word    (i_readdata),
    .i_ld_blk  (w_ld_blk),
    .i_blk     (i_blk_in_data),
    .i_rd_idx  (r_idx),
    .o_blk     (w_blk),
    .o_word    (w_word)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_left  <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == ST_IDLE) && i_start && w_range_bad;
      if (w_accept) begin
        r_src  <= i_src_addr;
        r_dst  <= i_dst_addr;
        r_left <= i_num_blocks;
        r_idx  <= '0;
      end
      if ((r_state == ST_RD) || (r_state == ST_WR)) begin
        r_idx <= r_idx + 2'd1;
      end
      if (r_state == ST_NEXT) begin
        r_src  <= r_src + AW'(WORDS_PER_BLK);
        r_dst  <= r_dst + AW'(WORDS_PER_BLK);
        r_left <= r_left - NBW'(1);
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    o_busy          = 1'b1;
    o_done          = 1'b0;
    o_chipselect    = 1'b0;
    o_write         = 1'b0;
    o_byteenable    = 4'h0;
    o_address       = '0;
    o_writedata     = '0;
    o_blk_out_valid = 1'b0;
    o_blk_in_ready  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (w_accept) begin
          w_next = (i_num_blocks == '0) ? ST_DONE : ST_RD;
        end
      end
      ST_RD: begin
        o_chipselect = 1'b1;
        o_address    = r_src + AW'(r_idx);
        if (r_idx == 2'd3) w_next = ST_RD_LAST;
      end
      ST_RD_LAST: w_next = ST_OFFER;
      ST_OFFER: begin
        o_blk_out_valid = 1'b1;
        if (i_blk_out_ready) w_next = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        o_blk_in_ready = 1'b1;
        if (i_blk_in_valid) w_next = ST_WR;
      end
      ST_WR: begin
        o_chipselect = 1'b1;
        o_write      = 1'b1;
        o_byteenable = 4'hF;
        o_address    = r_dst + AW'(r_idx);
        o_writedata  = w_word;
        if (r_idx == 2'd3) begin
          w_next = (r_left == NBW'(1)) ? ST_DONE : ST_NEXT;
        end
      end
      ST_NEXT: w_next = ST_RD;
      ST_DONE: begin
        o_busy = 1'b0;
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign o_err          = r_err;
  assign o_clken        = 1'b1;
  assign o_blk_out_data = w_blk;

endmodule

// File: tb/tb_aes_mem_block_dma.sv
// Scoreboard bench: drivers push expected blocks/writes/done cycles, a negedge
// monitor pops and compares whenever the DUT presents them.
module tb_aes_mem_block_dma;
  localparam int DEPTH = 25000;
  localparam int AW    = 15;
  localparam int NBW   = 13;

  logic           clk = 1'b0;
  logic           i_reset, i_start;
  logic [AW-1:0]  i_src_addr, i_dst_addr;
  logic [NBW-1:0] i_num_blocks;
  logic           o_busy, o_done, o_err, o_chipselect, o_write, o_clken;
  logic [AW-1:0]  o_address;
  logic [3:0]     o_byteenable;
  logic [31:0]    o_writedata;
  logic [31:0]    i_readdata = 32'h0;
  logic [127:0]   o_blk_out_data, i_blk_in_data;
  logic           o_blk_out_valid, i_blk_out_ready, i_blk_in_valid, o_blk_in_ready;

  always #5 clk = ~clk;

  aes_mem_block_dma #(.DEPTH(DEPTH), .AW(AW), .NBW(NBW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
    .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_num_blocks(i_num_blocks),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_address(o_address), .o_chipselect(o_chipselect), .o_write(o_write),
    .o_byteenable(o_byteenable), .o_writedata(o_writedata), .i_readdata(i_readdata),
    .o_clken(o_clken), .o_blk_out_data(o_blk_out_data), .o_blk_out_valid(o_blk_out_valid),
    .i_blk_out_ready(i_blk_out_ready), .i_blk_in_data(i_blk_in_data),
    .i_blk_in_valid(i_blk_in_valid), .o_blk_in_ready(o_blk_in_ready)
  );

  // On-chip memory model: one-cycle read latency, plus a bench backdoor write port.
  logic [31:0]   mem [0:DEPTH-1];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_data = '0;
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (o_chipselect && o_write) mem[o_address] <= o_writedata;
    if (o_chipselect && !o_write) i_readdata <= mem[o_address];
  end

  typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;
  logic [127:0] q_blk[$];
  wr_t          q_wr[$];
  int           q_done[$];
  int           q_err[$];
  int checks = 0, errors = 0;
  int edge_cnt = 0, start_edge = 0, cs_count = 0;
  int out_delay = 0, in_delay = 0;
  logic [127:0] pending_res = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor
  initial begin
    int   cyc;
    wr_t  e;
    logic stall_prev;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc = edge_cnt - start_edge + 1;
      if (o_chipselect) cs_count++;
      if (stall_prev) chk("stall_valid_held", 128'(o_blk_out_valid), 128'd1);
      stall_prev = o_blk_out_valid && !i_blk_out_ready;
      if (o_blk_out_valid && i_blk_out_ready) begin
        pending_res = ~o_blk_out_data;
        if (q_blk.size() == 0) chk("unexpected_blk_cnt", 128'(q_blk.size()), 128'd1);
        else chk("blk_out_data", o_blk_out_data, q_blk.pop_front());
      end else if (o_blk_out_valid) begin
        if (q_blk.size() != 0) chk("stall_blk_stable", o_blk_out_data, q_blk[0]);
        chk("stall_out_bus_idle", 128'(o_chipselect), 128'd0);
      end
      if (o_blk_in_ready && !i_blk_in_valid) chk("stall_in_bus_idle", 128'(o_chipselect), 128'd0);
      if (o_chipselect && o_write) begin
        if (q_wr.size() == 0) chk("unexpected_write_cnt", 128'(q_wr.size()), 128'd1);
        else begin
          e = q_wr.pop_front();
          chk("wr_addr", 128'(o_address), 128'(e.a));
          chk("wr_data", 128'(o_writedata), 128'(e.d));
          chk("wr_byteen", 128'(o_byteenable), 128'(4'hF));
        end
      end
      if (o_done) begin
        if (q_done.size() == 0) chk("unexpected_done_cnt", 128'(q_done.size()), 128'd1);
        else chk("done_cycle", 128'(cyc), 128'(q_done.pop_front()));
        chk("busy_low_at_done", 128'(o_busy), 128'd0);
      end
      if (o_err) begin
        if (q_err.size() == 0) chk("unexpected_err_cnt", 128'(q_err.size()), 128'd1);
        else chk("err_cycle", 128'(cyc), 128'(q_err.pop_front()));
      end
    end
  end

  // AES core stub: returns the bitwise inverse after configurable stalls.
  initial begin
    int oc, ic;
    oc = 0; ic = 0;
    i_blk_out_ready = 1'b0; i_blk_in_valid = 1'b0; i_blk_in_data = '0;
    forever begin
      @(posedge clk); #1;
      if (o_blk_out_valid) begin
        if (oc >= out_delay) i_blk_out_ready = 1'b1;
        else begin i_blk_out_ready = 1'b0; oc++; end
      end else begin
        i_blk_out_ready = 1'b0; oc = 0;
      end
      if (o_blk_in_ready) begin
        if (ic >= in_delay) begin i_blk_in_valid = 1'b1; i_blk_in_data = pending_res; end
        else begin i_blk_in_valid = 1'b0; ic++; end
      end else begin
        i_blk_in_valid = 1'b0; ic = 0;
      end
    end
  end

  task automatic poke(input logic [AW-1:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [NBW-1:0] n);
    i_start = 1'b1; i_src_addr = s; i_dst_addr = d; i_num_blocks = n;
    start_edge = edge_cnt + 1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic stray_start();
    i_start = 1'b1; i_src_addr = 15'd24996; i_num_blocks = 13'd2;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic expect_block(input logic [AW-1:0] d, input logic [31:0] w0, w1, w2, w3);
    q_blk.push_back({w0, w1, w2, w3});
    q_wr.push_back('{a: d,           d: ~w0});
    q_wr.push_back('{a: d + 15'd1,   d: ~w1});
    q_wr.push_back('{a: d + 15'd2,   d: ~w2});
    q_wr.push_back('{a: d + 15'd3,   d: ~w3});
  endtask

  task automatic wait_jobs(input int budget);
    int n;
    n = 0;
    while ((q_done.size() != 0 || q_err.size() != 0) && n < budget) begin
      @(posedge clk); n++;
    end
    #1;
    chk("job_timeout", 128'(q_done.size() + q_err.size()), 128'd0);
    q_done.delete(); q_err.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("blk_q_drained", 128'(q_blk.size()), 128'd0);
    chk("wr_q_drained", 128'(q_wr.size()), 128'd0);
    q_blk.delete(); q_wr.delete();
  endtask

  task automatic check_rst(input string nm);
    chk({nm, "_ctl"}, 128'({o_busy, o_done, o_err, o_chipselect, o_write, o_clken,
                            o_blk_out_valid, o_blk_in_ready}), 128'(8'b0000_0100));
    chk({nm, "_addr"}, 128'(o_address), 128'd0);
    chk({nm, "_be_wd"}, 128'({o_byteenable, o_writedata}), 128'd0);
    chk({nm, "_blk"}, o_blk_out_data, 128'd0);
  endtask

  task automatic chk_mem(input string nm, input logic [AW-1:0] a, input logic [31:0] exp);
    chk(nm, 128'(mem[a]), 128'(exp));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cs0;
    i_reset = 1'b1; i_start = 1'b0; i_src_addr = '0; i_dst_addr = '0; i_num_blocks = '0;
    repeat (3) @(posedge clk);
    #1;
    check_rst("reset");
    i_reset = 1'b0;
    @(posedge clk); #1;
    check_rst("idle");

    // Single block, hand-computed vectors.
    poke(15'h0000, 32'h00112233); poke(15'h0001, 32'h44556677);
    poke(15'h0002, 32'h8899AABB); poke(15'h0003, 32'hCCDDEEFF);
    q_blk.push_back(128'h00112233_44556677_8899AABB_CCDDEEFF);
    q_wr.push_back('{a: 15'h100, d: 32'hFFEEDDCC});
    q_wr.push_back('{a: 15'h101, d: 32'hBBAA9988});
    q_wr.push_back('{a: 15'h102, d: 32'h77665544});
    q_wr.push_back('{a: 15'h103, d: 32'h33221100});
    q_done.push_back(12);
    do_start(15'h0000, 15'h0100, 13'd1);
    wait_jobs(100);
    chk_mem("single_mem0", 15'h100, 32'hFFEEDDCC);
    chk_mem("single_mem3", 15'h103, 32'h33221100);

    // Backpressure: ready low 5 cycles, result 7 cycles late.
    poke(15'h10, 32'hDEADBEEF); poke(15'h11, 32'h01234567);
    poke(15'h12, 32'h89ABCDEF); poke(15'h13, 32'hCAFEF00D);
    out_delay = 5; in_delay = 7;
    expect_block(15'h300, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D);
    q_done.push_back(24);
    do_start(15'h0010, 15'h0300, 13'd1);
    wait_jobs(200);
    out_delay = 0; in_delay = 0;
    chk_mem("bp_mem0", 15'h300, 32'h21524110);
    chk_mem("bp_mem3", 15'h303, 32'h35010FF2);

    // Range errors on source and on destination; neither may touch the bus.
    cs0 = cs_count;
    q_err.push_back(1);
    do_start(15'd24996, 15'd0, 13'd2);
    for (int k = 0; k < 4; k++) begin
      chk("range_busy", 128'(o_busy), 128'd0);
      @(posedge clk); #1;
    end
    wait_jobs(20);
    q_err.push_back(1);
    do_start(15'd0, 15'd24997, 13'd1);
    wait_jobs(20);
    chk("range_no_bus", 128'(cs_count), 128'(cs0));

    // Exactly-fitting destination at the top of memory is legal.
    expect_block(15'd24996, 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
    q_done.push_back(12);
    do_start(15'h0000, 15'd24996, 13'd1);
    wait_jobs(100);
    chk_mem("top_mem3", 15'd24999, 32'h33221100);

    // Zero blocks: done in cycle 1, no bus cycles.
    cs0 = cs_count;
    q_done.push_back(1);
    do_start(15'h0040, 15'h0040, 13'd0);
    wait_jobs(20);
    chk("zero_no_bus", 128'(cs_count), 128'(cs0));

    // Three blocks in place with stray starts during RD and NEXT.
    for (int i = 0; i < 12; i++) poke(15'h200 + 15'(i), 32'hC0DE0000 + 32'(i));
    for (int b = 0; b < 3; b++)
      expect_block(15'h200 + 15'(4*b), 32'hC0DE0000 + 32'(4*b), 32'hC0DE0001 + 32'(4*b),
                   32'hC0DE0002 + 32'(4*b), 32'hC0DE0003 + 32'(4*b));
    q_done.push_back(36);
    do_start(15'h0200, 15'h0200, 13'd3);
    repeat (3) @(posedge clk);
    #1; stray_start();
    repeat (7) @(posedge clk);
    #1; stray_start();
    wait_jobs(200);
    chk_mem("multi_mem0", 15'h200, 32'h3F21FFFF);
    chk_mem("multi_mem11", 15'h20B, 32'h3F21FFF4);

    // Reset while the second write is on the bus.
    for (int i = 0; i < 8; i++) begin
      poke(15'h400 + 15'(i), 32'h0BAD0000 + 32'(i));
      poke(15'h500 + 15'(i), 32'h5A5A0000 + 32'(i));
    end
    q_blk.push_back(128'h0BAD0000_0BAD0001_0BAD0002_0BAD0003);
    q_wr.push_back('{a: 15'h500, d: 32'hF452FFFF});
    q_wr.push_back('{a: 15'h501, d: 32'hF452FFFE});
    do_start(15'h0400, 15'h0500, 13'd2);
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_wr2_addr", 128'({o_write, o_address}), 128'({1'b1, 15'h501}));
    i_reset = 1'b1;
    @(posedge clk); #1;
    check_rst("midrst");
    i_reset = 1'b0;
    @(posedge clk); #1;
    chk_mem("midrst_mem1", 15'h501, 32'hF452FFFE);
    chk_mem("midrst_mem2", 15'h502, 32'h5A5A0002);
    chk_mem("midrst_mem4", 15'h504, 32'h5A5A0004);
    wait_jobs(10);
    expect_block(15'h500, 32'h0BAD0000, 32'h0BAD0001, 32'h0BAD0002, 32'h0BAD0003);
    expect_block(15'h504, 32'h0BAD0004, 32'h0BAD0005, 32'h0BAD0006, 32'h0BAD0007);
    q_done.push_back(24);
    do_start(15'h0400, 15'h0500, 13'd2);
    wait_jobs(200);
    chk_mem("rerun_mem3", 15'h503, 32'hF452FFFC);
    chk_mem("rerun_mem7", 15'h507, 32'hF452FFF8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
